hovalaag_host_driver: RTL and testbench
=======================================

Name: hovalaag_host_driver

Overview:
Host-side initiator for the Hovalaag CPU wrapper's 6-bit-in / 8-bit-out one-hot-addressed bus.
- Takes whole 32-bit instructions and 12-bit IN1/IN2 stream words on valid/ready interfaces.
- Serialises them into the wrapper's write slots, fires execute, and reads back status, PC and OUT.
- Delivers OUT words on OUT1/OUT2 valid/ready streams and pops IN words when the CPU advances.

Parameters:
RD_WAIT, 0, extra bus cycles each read state is held before sampling hv_rdata (0..3; bus settle for off-chip wiring).

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high; must be asserted together with the wrapper's reset
instr_data  in  32  instruction word
instr_valid  in  1  instruction offered
instr_ready  out  1  instruction accepted this cycle
in1_data  in  12  IN1 stream head (first-word-fall-through)
in1_valid  in  1  IN1 head valid
in1_ready  out  1  pop IN1 head
in2_data / in2_valid / in2_ready  in/in/out  12/1/1  IN2 stream, same rules
out1_data  out  12  OUT1 word
out1_valid  out  1  OUT1 word valid
out1_ready  in  1  OUT1 consumer ready
out2_data / out2_valid / out2_ready  out/out/in  12/1/1  OUT2 stream, same rules
pc  out  8  PC read back after the last execute
step_done  out  1  one-cycle pulse per completed instruction
underflow  out  1  sticky: CPU advanced an input that was empty when loaded
busy  out  1  FSM not in IDLE
hv_addr  out  10  one-hot slot select to wrapper; 0 = no access
hv_wdata  out  6  data to wrapper io_in
hv_rdata  in  8  data from wrapper io_out

Behaviour:
- Reset values: all outputs 0. FSM goes to IDLE. in1_sent/in2_sent = 0. Cache valid. underflow cleared. Reset mid-instruction aborts with no pops and no pushes.
- IDLE: instr_ready=1, hv_addr=0. On instr_valid, latch instr and go to WI0.
- WI0..WI4: hv_addr=1<<k, hv_wdata=instr[6k+5:6k]. One cycle each.
- W1L, W1H, W2L, W2H: hv_addr bits 6, 7, 8, 9.
  - Data is the low or high 6 bits of the value to send.
  - The value to send is in1_data if in1_valid is high at W1L, else 12'h000. IN2 follows the same rule at W2L.
  - Record had1/had2 = valid at W1L/W2L.
  - Store the value sent in in1_sent/in2_sent. The high half is taken from the same registered value.
- EXEC: hv_addr=bit5, hv_wdata={4'b0, instr[31:30]}. Held 1+RD_WAIT cycles; sample status=hv_rdata[3:0] on the last cycle. hv_wdata is only valid on the first cycle; 0 afterwards.
- RDPC: hv_addr=bit6, held 1+RD_WAIT cycles, pc<=hv_rdata.
- If status[2] or status[3]:
  - RDLO (bit7): lo<=hv_rdata.
  - RDHI (bit8): hi<=hv_rdata[3:0]. Each held 1+RD_WAIT cycles.
  - PUSH: assert out1_valid (status[2]) or out2_valid (status[3]) with {hi,lo}. Data is held stable until ready.
  - Otherwise skip to ADV.
- ADV, one cycle:
  - in1_ready = status[0] & had1. in2_ready = status[1] & had2.
  - underflow |= (status[0] & !had1) | (status[1] & !had2).
  - step_done=1, then go to IDLE.
- Latency with RD_WAIT=0, from accept: 13 cycles back to IDLE with no output. With output, 16 cycles plus PUSH stall.
- Boundaries:
  - A valid IN word arriving after W1L/W2L is not popped that instruction.
  - Status bits 2 and 3 both set: OUT1 takes priority. This is not produced by a legal wrapper.
  - hv_addr is always one-hot or zero.

Optional Feature:
HOVHOST_IN_CACHE_EN
- Defined: W1L/W1H are skipped when the value to send equals in1_sent, and W2L/W2H likewise. had1/had2 are still recorded at the cycle the skip decision is made. This is correct only because reset initialises in1_sent/in2_sent to 0, matching the wrapper's reset. Best case is 9 cycles per instruction with no output.
- Undefined: all four IN slots are written every instruction.

Test Plan:
- Reset, then instr 32'h0000_0000 with no inputs -> hv_addr sequence 001,002,004,008,010,040,080,100,200,020,040; step_done at cycle 12; no pops; underflow=0.
- instr with bit14=1, bit13=0; hv_rdata returns 0x05 at EXEC and 0xAB/0x03 at RDLO/RDHI -> out1_data=12'h3AB; in1 popped once; out1_ready held low 5 cycles keeps data stable.
- Status 0x02 with in2_valid=0 at W2L -> no in2_ready pulse, underflow=1 and sticky until reset.
- Back-to-back instructions with in1_data=12'h555 unchanged: with HOVHOST_IN_CACHE_EN, the second instruction omits bit6/bit7 writes; without it, they are present.
- RD_WAIT=2 -> EXEC/RDPC each held 3 cycles; pc equals hv_rdata on the third RDPC cycle. Reset asserted during RDLO -> outputs 0, IDLE next cycle.

Source files
------------

// File: rtl/hovalaag_host_driver_if.sv
// One-hot addressed 6-bit-in / 8-bit-out bus between the host driver (master) and the Hovalaag wrapper (slave).
interface hovalaag_host_driver_if;
   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned WDATA_W = 6;
   localparam int unsigned RDATA_W = 8;

   logic [ADDR_W-1:0]  hv_addr;
   logic [WDATA_W-1:0] hv_wdata;
   logic [RDATA_W-1:0] hv_rdata;

   modport master (output hv_addr, output hv_wdata, input hv_rdata);
   modport slave  (input hv_addr, input hv_wdata, output hv_rdata);
endinterface

// File: rtl/hovalaag_host_driver.sv
// Host driver for the Hovalaag wrapper: writes instruction and IN slots, executes, reads status/PC/OUT, pops/pushes streams.
// Optional feature macro HOVHOST_IN_CACHE_EN: skip IN slot writes whose value equals the last value sent.
module hovalaag_host_driver #(
   parameter int unsigned RD_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_data,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [11:0] in1_data,
   input  logic        in1_valid,
   output logic        in1_ready,
   input  logic [11:0] in2_data,
   input  logic        in2_valid,
   output logic        in2_ready,
   output logic [11:0] out1_data,
   output logic        out1_valid,
   input  logic        out1_ready,
   output logic [11:0] out2_data,
   output logic        out2_valid,
   input  logic        out2_ready,
   output logic [7:0]  pc,
   output logic        step_done,
   output logic        underflow,
   output logic        busy,
   hovalaag_host_driver_if.master hv
);
   localparam int unsigned WORD_W = 12;
   localparam int unsigned SLOT_W = 6;
   localparam int unsigned ADDR_W = 10;

   typedef enum logic [3:0] {
      IDLE, WI, W1L, W1H, W2L, W2H, EXEC, RDPC, RDLO, RDHI, PUSH, ADV
   } state_t;

   state_t             r_state, w_state_d;
   logic [2:0]         r_idx, w_idx_d;
   logic [1:0]         r_wait, w_wait_d;
   logic [31:0]        r_instr, w_instr_d;
   logic               r_had1, w_had1_d, r_had2, w_had2_d;
   logic [WORD_W-1:0]  r_in1_sent, w_in1_sent_d, r_in2_sent, w_in2_sent_d;
   logic [3:0]         r_status, w_status_d;
   logic [7:0]         r_lo, w_lo_d, r_pc, w_pc_d;
   logic               r_underflow, w_underflow_d;
   logic [WORD_W-1:0]  r_out1_data, w_out1_data_d, r_out2_data, w_out2_data_d;
   logic               r_instr_ready, w_instr_ready_d, r_busy, w_busy_d, r_step_done, w_step_done_d;
   logic               r_in1_ready, w_in1_ready_d, r_in2_ready, w_in2_ready_d;
   logic               r_out1_valid, w_out1_valid_d, r_out2_valid, w_out2_valid_d;
   logic [ADDR_W-1:0]  r_hv_addr, w_hv_addr_d;
   logic [SLOT_W-1:0]  w_wdata;
   logic [WORD_W-1:0]  w_val1, w_val2;
   logic               w_last;

   // Slot select driven while in a given state; registered one cycle ahead from the next state.
   function automatic logic [ADDR_W-1:0] slot_addr(input state_t s, input logic [2:0] idx);
      case (s)
         WI:          slot_addr = 10'd1 << idx;
         W1L, RDPC:   slot_addr = 10'h040;
         W1H, RDLO:   slot_addr = 10'h080;
         W2L, RDHI:   slot_addr = 10'h100;
         W2H:         slot_addr = 10'h200;
         EXEC:        slot_addr = 10'h020;
         default:     slot_addr = '0;
      endcase
   endfunction

   always_comb begin
      w_state_d     = r_state;
      w_idx_d       = r_idx;
      w_wait_d      = '0;
      w_instr_d     = r_instr;
      w_had1_d      = r_had1;
      w_had2_d      = r_had2;
      w_in1_sent_d  = r_in1_sent;
      w_in2_sent_d  = r_in2_sent;
      w_status_d    = r_status;
      w_lo_d        = r_lo;
      w_pc_d        = r_pc;
      w_underflow_d = r_underflow;
      w_out1_data_d = r_out1_data;
      w_out2_data_d = r_out2_data;
      w_wdata       = '0;
      w_last        = (r_wait == 2'(RD_WAIT));
      w_val1        = in1_valid ? in1_data : '0;
      w_val2        = in2_valid ? in2_data : '0;

      case (r_state)
         IDLE: if (instr_valid && r_instr_ready) begin
            w_instr_d = instr_data;
            w_idx_d   = '0;
            w_state_d = WI;
         end
         WI: begin
            w_wdata = SLOT_W'(r_instr >> (5'd6 * 5'(r_idx)));
            if (r_idx != 3'd4) begin
               w_idx_d = r_idx + 3'd1;
            end else begin
`ifdef HOVHOST_IN_CACHE_EN
               w_had1_d     = in1_valid;
               w_in1_sent_d = w_val1;
               if (w_val1 != r_in1_sent) begin
                  w_state_d = W1L;
               end else begin
                  w_had2_d     = in2_valid;
                  w_in2_sent_d = w_val2;
                  w_state_d    = (w_val2 != r_in2_sent) ? W2L : EXEC;
               end
`else
               w_state_d = W1L;
`endif
            end
         end
         W1L: begin
`ifdef HOVHOST_IN_CACHE_EN
            w_wdata      = r_in1_sent[5:0];
`else
            w_had1_d     = in1_valid;
            w_in1_sent_d = w_val1;
            w_wdata      = w_val1[5:0];
`endif
            w_state_d = W1H;
         end
         W1H: begin
            w_wdata = r_in1_sent[11:6];
`ifdef HOVHOST_IN_CACHE_EN
            w_had2_d     = in2_valid;
            w_in2_sent_d = w_val2;
            w_state_d    = (w_val2 != r_in2_sent) ? W2L : EXEC;
`else
            w_state_d = W2L;
`endif
         end
         W2L: begin
`ifdef HOVHOST_IN_CACHE_EN
            w_wdata      = r_in2_sent[5:0];
`else
            w_had2_d     = in2_valid;
            w_in2_sent_d = w_val2;
            w_wdata      = w_val2[5:0];
`endif
            w_state_d = W2H;
         end
         W2H: begin
            w_wdata   = r_in2_sent[11:6];
            w_state_d = EXEC;
         end
         // Read states hold for 1+RD_WAIT cycles and sample on the last one.
         EXEC: begin
            if (r_wait == '0) w_wdata = {4'b0, r_instr[31:30]};
            if (w_last) begin
               w_status_d = hv.hv_rdata[3:0];
               w_state_d  = RDPC;
            end else begin
               w_wait_d = r_wait + 2'd1;
            end
         end
         RDPC: begin
            if (w_last) begin
               w_pc_d    = hv.hv_rdata;
               w_state_d = (r_status[2] || r_status[3]) ? RDLO : ADV;
            end else begin
               w_wait_d = r_wait + 2'd1;
            end
         end
         RDLO: begin
            if (w_last) begin
               w_lo_d    = hv.hv_rdata;
               w_state_d = RDHI;
            end else begin
               w_wait_d = r_wait + 2'd1;
            end
         end
         RDHI: begin
            if (w_last) begin
               if (r_status[2]) w_out1_data_d = {hv.hv_rdata[3:0], r_lo};
               else             w_out2_data_d = {hv.hv_rdata[3:0], r_lo};
               w_state_d = PUSH;
            end else begin
               w_wait_d = r_wait + 2'd1;
            end
         end
         PUSH: if (r_status[2] ? out1_ready : out2_ready) w_state_d = ADV;
         ADV: begin
            w_underflow_d = r_underflow | (r_status[0] & ~r_had1) | (r_status[1] & ~r_had2);
            w_state_d     = IDLE;
         end
         default: w_state_d = IDLE;
      endcase

      w_instr_ready_d = (w_state_d == IDLE);
      w_busy_d        = (w_state_d != IDLE);
      w_step_done_d   = (w_state_d == ADV);
      w_in1_ready_d   = (w_state_d == ADV) & w_status_d[0] & w_had1_d;
      w_in2_ready_d   = (w_state_d == ADV) & w_status_d[1] & w_had2_d;
      w_out1_valid_d  = (w_state_d == PUSH) & w_status_d[2];
      w_out2_valid_d  = (w_state_d == PUSH) & ~w_status_d[2] & w_status_d[3];
      w_hv_addr_d     = slot_addr(w_state_d, w_idx_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_idx         <= '0;
         r_wait        <= '0;
         r_instr       <= '0;
         r_had1        <= 1'b0;
         r_had2        <= 1'b0;
         r_in1_sent    <= '0;
         r_in2_sent    <= '0;
         r_status      <= '0;
         r_lo          <= '0;
         r_pc          <= '0;
         r_underflow   <= 1'b0;
         r_out1_data   <= '0;
         r_out2_data   <= '0;
         r_instr_ready <= 1'b0;
         r_busy        <= 1'b0;
         r_step_done   <= 1'b0;
         r_in1_ready   <= 1'b0;
         r_in2_ready   <= 1'b0;
         r_out1_valid  <= 1'b0;
         r_out2_valid  <= 1'b0;
         r_hv_addr     <= '0;
      end else begin
         r_state       <= w_state_d;
         r_idx         <= w_idx_d;
         r_wait        <= w_wait_d;
         r_instr       <= w_instr_d;
         r_had1        <= w_had1_d;
         r_had2        <= w_had2_d;
         r_in1_sent    <= w_in1_sent_d;
         r_in2_sent    <= w_in2_sent_d;
         r_status      <= w_status_d;
         r_lo          <= w_lo_d;
         r_pc          <= w_pc_d;
         r_underflow   <= w_underflow_d;
         r_out1_data   <= w_out1_data_d;
         r_out2_data   <= w_out2_data_d;
         r_instr_ready <= w_instr_ready_d;
         r_busy        <= w_busy_d;
         r_step_done   <= w_step_done_d;
         r_in1_ready   <= w_in1_ready_d;
         r_in2_ready   <= w_in2_ready_d;
         r_out1_valid  <= w_out1_valid_d;
         r_out2_valid  <= w_out2_valid_d;
         r_hv_addr     <= w_hv_addr_d;
      end
   end

   // hv_wdata stays combinational: IN1/IN2 low halves are sampled live in their own slot cycle.
   assign hv.hv_addr  = r_hv_addr;
   assign hv.hv_wdata = w_wdata;
   assign instr_ready = r_instr_ready;
   assign in1_ready   = r_in1_ready;
   assign in2_ready   = r_in2_ready;
   assign out1_data   = r_out1_data;
   assign out1_valid  = r_out1_valid;
   assign out2_data   = r_out2_data;
   assign out2_valid  = r_out2_valid;
   assign pc          = r_pc;
   assign step_done   = r_step_done;
   assign underflow   = r_underflow;
   assign busy        = r_busy;
endmodule

// File: tb/tb_hovalaag_host_driver.sv
// Scoreboard bench for hovalaag_host_driver: RD_WAIT=0 instance for bus/stream behaviour, RD_WAIT=2 instance for read hold and reset abort.
module tb_hovalaag_host_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Instance A: RD_WAIT = 0
   logic        reset, instr_valid, instr_ready;
   logic [31:0] instr_data;
   logic [11:0] in1_data, in2_data, out1_data, out2_data;
   logic        in1_valid, in1_ready, in2_valid, in2_ready;
   logic        out1_valid, out1_ready, out2_valid, out2_ready;
   logic [7:0]  pc;
   logic        step_done, underflow, busy;
   hovalaag_host_driver_if u_bus ();

   hovalaag_host_driver #(.RD_WAIT(0)) u_dut (
      .clk(clk), .reset(reset),
      .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
      .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
      .pc(pc), .step_done(step_done), .underflow(underflow), .busy(busy),
      .hv(u_bus.master)
   );

   // Instance B: RD_WAIT = 2
   logic        b_reset, b_instr_valid, b_instr_ready;
   logic [31:0] b_instr_data;
   logic [11:0] b_in1_data, b_in2_data, b_out1_data, b_out2_data;
   logic        b_in1_valid, b_in1_ready, b_in2_valid, b_in2_ready;
   logic        b_out1_valid, b_out1_ready, b_out2_valid, b_out2_ready;
   logic [7:0]  b_pc;
   logic        b_step_done, b_underflow, b_busy;
   hovalaag_host_driver_if u_bus_b ();

   hovalaag_host_driver #(.RD_WAIT(2)) u_dut_b (
      .clk(clk), .reset(b_reset),
      .instr_data(b_instr_data), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
      .in1_data(b_in1_data), .in1_valid(b_in1_valid), .in1_ready(b_in1_ready),
      .in2_data(b_in2_data), .in2_valid(b_in2_valid), .in2_ready(b_in2_ready),
      .out1_data(b_out1_data), .out1_valid(b_out1_valid), .out1_ready(b_out1_ready),
      .out2_data(b_out2_data), .out2_valid(b_out2_valid), .out2_ready(b_out2_ready),
      .pc(b_pc), .step_done(b_step_done), .underflow(b_underflow), .busy(b_busy),
      .hv(u_bus_b.master)
   );

   // Wrapper read-side models
   logic [3:0] tb_status, b_status;
   logic [7:0] tb_pc, tb_lo, tb_hi, b_pcv, b_lo, b_hi;
   always_comb begin
      case (u_bus.hv_addr)
         10'h020: u_bus.hv_rdata = {4'h0, tb_status};
         10'h040: u_bus.hv_rdata = tb_pc;
         10'h080: u_bus.hv_rdata = tb_lo;
         10'h100: u_bus.hv_rdata = tb_hi;
         default: u_bus.hv_rdata = 8'h00;
      endcase
   end
   always_comb begin
      case (u_bus_b.hv_addr)
         10'h020: u_bus_b.hv_rdata = {4'h0, b_status};
         10'h040: u_bus_b.hv_rdata = b_pcv;
         10'h080: u_bus_b.hv_rdata = b_lo;
         10'h100: u_bus_b.hv_rdata = b_hi;
         default: u_bus_b.hv_rdata = 8'h00;
      endcase
   end

   // Scoreboard for instance A
   logic [15:0] q_bus[$];
   logic [11:0] q_out1[$], q_out2[$];
   logic [15:0] mon_bus;
   logic [11:0] mon_out;
   int pops1 = 0, pops2 = 0, steps = 0;
   logic [11:0] m_sent1 = '0, m_sent2 = '0;
   logic        m_uf = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (u_bus.hv_addr != '0) begin
            chk("bus_onehot", 32'($onehot(u_bus.hv_addr)), 32'd1);
            if (q_bus.size() == 0) begin
               chk("bus_extra", 32'({u_bus.hv_addr, u_bus.hv_wdata}), 32'd0);
            end else begin
               mon_bus = q_bus.pop_front();
               chk("bus_slot", 32'({u_bus.hv_addr, u_bus.hv_wdata}), 32'(mon_bus));
            end
         end
         if (out1_valid && out1_ready) begin
            if (q_out1.size() == 0) chk("out1_extra", 32'(q_out1.size()), 32'd1);
            else begin mon_out = q_out1.pop_front(); chk("out1_data", 32'(out1_data), 32'(mon_out)); end
         end
         if (out2_valid && out2_ready) begin
            if (q_out2.size() == 0) chk("out2_extra", 32'(q_out2.size()), 32'd1);
            else begin mon_out = q_out2.pop_front(); chk("out2_data", 32'(out2_data), 32'(mon_out)); end
         end
         if (in1_ready) pops1++;
         if (in2_ready) pops2++;
         if (step_done) steps++;
      end
   end

   task automatic run_instr(input logic [31:0] ins, input logic [3:0] st, input logic [7:0] pcv,
                            input logic [7:0] lo, input logic [7:0] hi, input int stall_n);
      logic [11:0] v1, v2;
      logic        wr1, wr2, outw, e1, e2;
      int nb, n, lat, a0, stall, p1, p2, s0;
      bit got;
      tb_status = st; tb_pc = pcv; tb_lo = lo; tb_hi = hi;
      nb = 0;
      for (int k = 0; k < 5; k++) begin q_bus.push_back({10'(10'd1 << k), ins[6*k +: 6]}); nb++; end
      v1 = in1_valid ? in1_data : 12'h000;
      v2 = in2_valid ? in2_data : 12'h000;
`ifdef HOVHOST_IN_CACHE_EN
      wr1 = (v1 != m_sent1);
      wr2 = (v2 != m_sent2);
`else
      wr1 = 1'b1;
      wr2 = 1'b1;
`endif
      if (wr1) begin q_bus.push_back({10'h040, v1[5:0]}); q_bus.push_back({10'h080, v1[11:6]}); nb += 2; m_sent1 = v1; end
      if (wr2) begin q_bus.push_back({10'h100, v2[5:0]}); q_bus.push_back({10'h200, v2[11:6]}); nb += 2; m_sent2 = v2; end
      q_bus.push_back({10'h020, 4'b0, ins[31:30]});
      q_bus.push_back({10'h040, 6'h00});
      nb += 2;
      outw = st[2] | st[3];
      if (outw) begin
         q_bus.push_back({10'h080, 6'h00}); q_bus.push_back({10'h100, 6'h00}); nb += 2;
         if (st[2]) q_out1.push_back({hi[3:0], lo});
         else       q_out2.push_back({hi[3:0], lo});
      end
      e1 = st[0] & in1_valid;
      e2 = st[1] & in2_valid;
      m_uf = m_uf | (st[0] & ~in1_valid) | (st[1] & ~in2_valid);
      p1 = pops1; p2 = pops2; s0 = steps;
      out1_ready = (stall_n == 0);
      out2_ready = (stall_n == 0);

      instr_data = ins; instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_timeout", 32'(n >= 50), 32'd0);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      a0 = cyc;

      got = 0; n = 0; stall = 0; lat = 0;
      while (!got && n < 300) begin
         @(negedge clk); n++;
         if (step_done) begin got = 1; lat = cyc - a0 + 1; end
         if (out1_valid && !out1_ready) begin
            chk("out1_hold", 32'(out1_data), 32'(q_out1.size() > 0 ? q_out1[0] : 12'hFFF));
            stall++;
         end
         if (out2_valid && !out2_ready) begin
            chk("out2_hold", 32'(out2_data), 32'(q_out2.size() > 0 ? q_out2[0] : 12'hFFF));
            stall++;
         end
         @(posedge clk); #1;
         out1_ready = (stall >= stall_n);
         out2_ready = (stall >= stall_n);
      end
      chk("step_timeout", 32'(got), 32'd1);
      if (!outw) chk("latency", 32'(lat), 32'(nb + 1));
      chk("pops1", 32'(pops1 - p1), 32'(e1));
      chk("pops2", 32'(pops2 - p2), 32'(e2));
      chk("steps", 32'(steps - s0), 32'd1);
      chk("pc", 32'(pc), 32'(pcv));
      chk("underflow", 32'(underflow), 32'(m_uf));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("bus_drained", 32'(q_bus.size()), 32'd0);
      chk("out_drained", 32'(q_out1.size() + q_out2.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int n, ne, nr, wd_bad;
      logic [5:0] w_first;
      bit done;
      reset = 1'b1; instr_valid = 1'b0; instr_data = '0;
      in1_valid = 1'b0; in1_data = '0; in2_valid = 1'b0; in2_data = '0;
      out1_ready = 1'b0; out2_ready = 1'b0;
      tb_status = '0; tb_pc = '0; tb_lo = '0; tb_hi = '0;
      b_reset = 1'b1; b_instr_valid = 1'b0; b_instr_data = '0;
      b_in1_valid = 1'b0; b_in1_data = '0; b_in2_valid = 1'b0; b_in2_data = '0;
      b_out1_ready = 1'b1; b_out2_ready = 1'b1;
      b_status = '0; b_pcv = '0; b_lo = '0; b_hi = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", 32'({instr_ready, busy, step_done, underflow, in1_ready, in2_ready, out1_valid, out2_valid}), 32'd0);
      chk("rst_bus", 32'({u_bus.hv_addr, u_bus.hv_wdata}), 32'd0);
      chk("rst_data", 32'({pc, out1_data}), 32'd0);
      reset = 1'b0; b_reset = 1'b0;
      @(posedge clk); #1;

      // No inputs, no output
      run_instr(32'h0000_0000, 4'h0, 8'h11, 8'h00, 8'h00, 0);
      // IN1 consumed, OUT1 produced with a 5-cycle consumer stall
      in1_valid = 1'b1; in1_data = 12'h123;
      run_instr(32'h0000_4000, 4'h5, 8'h22, 8'hAB, 8'h03, 5);
      // IN2 advanced while empty -> sticky underflow
      in1_valid = 1'b0;
      run_instr(32'h8000_0FC0, 4'h2, 8'h33, 8'h00, 8'h00, 0);
      run_instr(32'h1234_5678, 4'h0, 8'h44, 8'h00, 8'h00, 0);
      // Unchanged IN words back to back
      in1_valid = 1'b1; in1_data = 12'h555; in2_valid = 1'b1; in2_data = 12'h0AA;
      run_instr(32'hC0FF_EE01, 4'h0, 8'h55, 8'h00, 8'h00, 0);
      run_instr(32'h0BAD_F00D, 4'h0, 8'h66, 8'h00, 8'h00, 0);
      // OUT2 path; hi nibble masked
      in1_valid = 1'b0;
      run_instr(32'h0000_2000, 4'hA, 8'h77, 8'h5C, 8'hE7, 2);
      // Both OUT flags: OUT1 wins
      run_instr(32'h4000_0003, 4'hC, 8'h88, 8'h11, 8'h02, 0);
      // Both inputs consumed
      in1_valid = 1'b1; in1_data = 12'h7FF; in2_valid = 1'b1; in2_data = 12'hFFF;
      run_instr(32'hFFFF_FFFF, 4'h3, 8'h99, 8'h00, 8'h00, 0);

      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst2_underflow", 32'(underflow), 32'd0);
      chk("rst2_pc", 32'(pc), 32'd0);
      reset = 1'b0;

      // Instance B: read hold with RD_WAIT=2, then reset during RDLO
      b_status = 4'h4; b_pcv = 8'h5A; b_lo = 8'h12; b_hi = 8'h03;
      b_instr_data = 32'h4000_0000; b_instr_valid = 1'b1;
      n = 0;
      while (!b_instr_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("b_accept_timeout", 32'(n >= 50), 32'd0);
      @(posedge clk); #1;
      b_instr_valid = 1'b0;
      ne = 0; nr = 0; wd_bad = 0; w_first = '0; done = 0; n = 0;
      while (!done && n < 100) begin
         @(negedge clk); n++;
         case (u_bus_b.hv_addr)
            10'h020: begin
               if (ne == 0) w_first = u_bus_b.hv_wdata;
               else if (u_bus_b.hv_wdata != '0) wd_bad++;
               ne++;
            end
            10'h040: if (ne > 0) nr++;
            10'h080: if (ne > 0) done = 1;
            default: ;
         endcase
      end
      chk("b_rdlo_timeout", 32'(done), 32'd1);
      chk("b_exec_cycles", 32'(ne), 32'd3);
      chk("b_exec_wdata", 32'(w_first), 32'd1);
      chk("b_exec_wdata_later", 32'(wd_bad), 32'd0);
      chk("b_rdpc_cycles", 32'(nr), 32'd3);
      chk("b_pc", 32'(b_pc), 32'h5A);
      b_reset = 1'b1;
      @(posedge clk); #1;
      chk("b_rst_outs", 32'({b_instr_ready, b_busy, b_step_done, b_underflow, b_in1_ready, b_in2_ready, b_out1_valid, b_out2_valid}), 32'd0);
      chk("b_rst_bus", 32'({u_bus_b.hv_addr, u_bus_b.hv_wdata}), 32'd0);
      chk("b_rst_pc", 32'(b_pc), 32'd0);
      b_reset = 1'b0;
      @(posedge clk); #1;
      chk("b_idle_after_rst", 32'({b_busy, b_instr_ready}), 32'd1);
      repeat (20) begin
         @(negedge clk);
         chk("b_no_push_after_abort", 32'({b_out1_valid, b_step_done, u_bus_b.hv_addr}), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
